// File: rtl/avr_cpu_pkg.sv
// Shared constants for the AVR multiply unit:
// opcode encodings, FSM state codes, R0/R1 addresses.
package avr_cpu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULS   = 3'd1,
    OP_MULSU  = 3'd2,
    OP_FMUL   = 3'd3,
    OP_FMULS  = 3'd4,
    OP_FMULSU = 3'd5
  } mul_op_e;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WR_LO = 2'd1;
  localparam logic [1:0] ST_WR_HI = 2'd2;

  localparam logic [4:0] ADDR_R0 = 5'd0;
  localparam logic [4:0] ADDR_R1 = 5'd1;

endpackage

// File: rtl/avr_cpu_multiplier_if.sv
// Multiply-unit bus: start/op/operands in,
// register-file write port and status flags out.
interface avr_cpu_multiplier_if;
  logic       start;
  logic [2:0] mul_op;
  logic [7:0] rd_val;
  logic [7:0] rr_val;
  logic       busy;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       flags_valid;
  logic       flag_c;
  logic       flag_z;

  modport master (
    output start, mul_op, rd_val, rr_val,
    input  busy, wr_en, wr_addr, wr_data,
    input  flags_valid, flag_c, flag_z
  );

  modport slave (
    input  start, mul_op, rd_val, rr_val,
    output busy, wr_en, wr_addr, wr_data,
    output flags_valid, flag_c, flag_z
  );
endinterface

// File: rtl/avr_cpu_mul_core.sv
// Combinational AVR multiply datapath.
// in: mul_op, rd_val, rr_val; out: result, c, z.
module avr_cpu_mul_core
  import avr_cpu_pkg::*;
(
  input  logic [2:0]  mul_op_i,
  input  logic [7:0]  rd_val_i,
  input  logic [7:0]  rr_val_i,
  output logic [15:0] result_o,
  output logic        c_o,
  output logic        z_o
);

  logic        sd, sr, frac;
  logic [15:0] a, b, p;

  always_comb begin
    sd   = 1'b0;
    sr   = 1'b0;
    frac = 1'b0;
    case (mul_op_i)
      OP_MULS:   begin sd = 1'b1; sr = 1'b1; end
      OP_MULSU:  sd = 1'b1;
      OP_FMUL:   frac = 1'b1;
      OP_FMULS:  begin frac = 1'b1; sd = 1'b1; sr = 1'b1; end
      OP_FMULSU: begin frac = 1'b1; sd = 1'b1; end
      default:   ;
    endcase
  end

  // Extending to 16 bits and keeping the low 16 bits of
  // the product equals the low half of a 9x9 signed multiply.
  assign a = {{8{sd & rd_val_i[7]}}, rd_val_i};
  assign b = {{8{sr & rr_val_i[7]}}, rr_val_i};
  assign p = a * b;

  assign result_o = frac ? {p[14:0], 1'b0} : p;
  assign c_o      = p[15];
  assign z_o      = (result_o == 16'h0000);

endmodule

// File: rtl/avr_cpu_multiplier.sv
// Two-cycle AVR multiplier: captures product at start,
// writes R0 then R1, strobes C/Z on the final cycle.
module avr_cpu_multiplier
  import avr_cpu_pkg::*;
(
  input  logic clk,
  input  logic rst,
  avr_cpu_multiplier_if.slave bus
);

  logic [1:0]  state_q, state_d;
  logic [15:0] prod_q, prod_d;
  logic        c_q, c_d;
  logic        z_q, z_d;
  logic [15:0] res;
  logic        res_c, res_z;
  logic        in_lo, in_hi;

  avr_cpu_mul_core u_core (
    .mul_op_i (bus.mul_op),
    .rd_val_i (bus.rd_val),
    .rr_val_i (bus.rr_val),
    .result_o (res),
    .c_o      (res_c),
    .z_o      (res_z)
  );

  always_comb begin
    state_d = ST_IDLE;
    prod_d  = prod_q;
    c_d     = c_q;
    z_d     = z_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_WR_LO;
          prod_d  = res;
          c_d     = res_c;
          z_d     = res_z;
        end
      end
      ST_WR_LO: state_d = ST_WR_HI;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      prod_q  <= 16'h0000;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      prod_q  <= prod_d;
      c_q     <= c_d;
      z_q     <= z_d;
    end
  end

  assign in_lo = (state_q == ST_WR_LO);
  assign in_hi = (state_q == ST_WR_HI);

  assign bus.busy        = in_lo | in_hi;
  assign bus.wr_en       = in_lo | in_hi;
  assign bus.wr_addr     = in_hi ? ADDR_R1 : ADDR_R0;
  assign bus.wr_data     = in_lo ? prod_q[7:0]
                         : in_hi ? prod_q[15:8]
                         : 8'h00;
  assign bus.flags_valid = in_hi;
  assign bus.flag_c      = c_q;
  assign bus.flag_z      = z_q;

endmodule

// File: doc/avr_cpu_multiplier.md
# avr_cpu_multiplier

Two-cycle hardware multiply unit for the AVR core, executing MUL, MULS, MULSU, FMUL, FMULS and FMULSU. It sits directly downstream of the CPU register file. It takes the Rd/Rr operands from the register file's two read ports, and its write port feeds the register file's single write path (address/data) to deposit the 16-bit product into R1:R0. The write is split over two consecutive cycles, low byte first. C and Z flags are handed to the status register on the final cycle.

## Interface
- No parameters.
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  request a multiply; sampled only when busy=0.
- mul_op  in  3  operation code (encodings in package, see Structure).
- rd_val  in  8  Rd operand (register file d_out).
- rr_val  in  8  Rr operand (register file r_out).
- busy  out  1  high while a write-back sequence is in progress.
- wr_en  out  1  register-file write enable.
- wr_addr  out  5  destination register: 5'd0 or 5'd1.
- wr_data  out  8  byte to write.
- flags_valid  out  1  one-cycle strobe; flag_c/flag_z are valid while high.
- flag_c  out  1  carry result.
- flag_z  out  1  zero result.

## Operation
- States: IDLE, WR_LO, WR_HI.
- IDLE, start=1:
  - capture product, C and Z into registers;
  - go to WR_LO.
- IDLE, start=0: stay in IDLE.
- WR_LO:
  - outputs: wr_en=1, wr_addr=0, wr_data=product[7:0];
  - next state WR_HI.
- WR_HI:
  - outputs: wr_en=1, wr_addr=1, wr_data=product[15:8], flags_valid=1;
  - next state IDLE.
- Outputs are decoded from registered state, so there is no combinational path from start or operands.
- busy=1 in WR_LO and WR_HI. A start asserted while busy is ignored and not queued.
- Operand extension to 9 bits:
  - MUL, FMUL: both operands zero-extended.
  - MULS, FMULS: both operands sign-extended.
  - MULSU, FMULSU: Rd sign-extended, Rr zero-extended.
- Raw product p = low 16 bits of the 9x9 signed product.
- Result:
  - MUL*: result = p, C = p[15].
  - FMUL*: result = p<<1 (bit 0 = 0), C = p[15] taken before the shift.
  - Z = (result == 16'h0000).
- Undefined mul_op codes (6, 7) behave as MUL.
- Reset values: state=IDLE; busy, wr_en, flags_valid, flag_c, flag_z all 0; wr_addr=0; wr_data=0.
- Outside WR_LO/WR_HI: wr_addr and wr_data are driven to 0, flag_c/flag_z hold their last values.

## Timing
- start sampled high at edge N (IDLE) → WR_LO during cycle N..N+1 → WR_HI during N+1..N+2 → IDLE after edge N+2.
- Total latency 2 cycles. The next start can be accepted at edge N+2 at the earliest (busy already 0 in that cycle? No: busy=1 during WR_HI, so the earliest accepted start is the one sampled at edge N+3).
- Operands are consumed only at edge N. Changes to rd_val/rr_val afterwards do not affect the result, including the core's own write of R0 during WR_LO.
- rst high at any edge, including mid-WR_LO or mid-WR_HI: go to IDLE and clear outputs per reset values. The partial write-back is abandoned (no WR_HI write, no flags_valid). rst dominates a simultaneous start.

## Structure
- Package avr_cpu_pkg:
  - mul_op encodings: MUL=3'd0, MULS=3'd1, MULSU=3'd2, FMUL=3'd3, FMULS=3'd4, FMULSU=3'd5;
  - state encoding;
  - R0/R1 address constants.
- Sub-module avr_cpu_mul_core, purely combinational: (mul_op, rd_val, rr_val) → (result[15:0], c, z).
- Top level: FSM, capture registers and output decode.

## Test plan
- MUL rd=0xFF rr=0xFF, start pulse → WR_LO writes R0=0x01, WR_HI writes R1=0xFE; C=1, Z=0; busy high exactly 2 cycles.
- MULSU rd=0x80 rr=0xFF → R1:R0=0x8080, C=1. MULS rd=0xFF rr=0x02 → 0xFFFE, C=1, Z=0.
- FMUL rd=0x40 rr=0x40 → 0x2000, C=0. FMULS rd=0x80 rr=0x80 → 0x8000, C=0.
- MUL rd=0x00 rr=0x5A → 0x0000 written, Z=1, C=0, flags_valid a single-cycle pulse in WR_HI.
- Start held high continuously with alternating operands → accepted at every third edge only; wr_en pattern 1,1,0 repeating; operand changes during busy do not alter results.
- rst asserted in WR_LO → next cycle IDLE, wr_en=0, no R1 write, flags_valid never pulses; a subsequent start completes normally.
